// File: rtl/femto_bus_pkg.sv
// Shared types and constants for the femto bus interconnect.
// The default region map routes the femto SoC peripherals by m_addr[31:16].
package femto_bus_pkg;

  localparam int DATA_W   = 32;
  localparam int REGION_W = 16;

  localparam logic [REGION_W-1:0] REGION_FLASH = 16'h0000;
  localparam logic [REGION_W-1:0] REGION_RAM   = 16'h0040;
  localparam logic [REGION_W-1:0] REGION_DPRAM = 16'h0041;
  localparam logic [REGION_W-1:0] REGION_MULT  = 16'h0042;
  localparam logic [REGION_W-1:0] REGION_UART  = 16'h0043;
  localparam logic [REGION_W-1:0] REGION_GPIO  = 16'h0044;
  localparam logic [REGION_W-1:0] REGION_BCD   = 16'h0001;
  localparam logic [REGION_W-1:0] REGION_DIV   = 16'h0045;

  // Entry 0 sits in the least-significant 16 bits.
  localparam logic [8*REGION_W-1:0] DEFAULT_REGION_MAP = {
    REGION_DIV, REGION_BCD, REGION_GPIO, REGION_UART,
    REGION_MULT, REGION_DPRAM, REGION_RAM, REGION_FLASH
  };

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_WR_WAIT  = 2'd2,
    ST_ERR_RESP = 2'd3
  } bus_state_t;

endpackage

// File: rtl/femto_bus_decode.sv
// Combinational region matcher: lowest matching table entry wins,
// otherwise the default channel is used if it exists.
module femto_bus_decode
  import femto_bus_pkg::*;
#(
  parameter int N_SLAVES = 8,
  parameter logic [N_SLAVES*REGION_W-1:0] REGION_MAP = DEFAULT_REGION_MAP,
  parameter int DEFAULT_SLAVE = 0,
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [REGION_W-1:0] region,
  output logic [SEL_W-1:0]    index,
  output logic                hit,
  output logic                mapped
);

  localparam logic DEFAULT_OK = (DEFAULT_SLAVE < N_SLAVES);

  logic match;

  // Descending scan so the lowest matching entry is the one left in index.
  always_comb begin
    index = SEL_W'(DEFAULT_SLAVE);
    hit   = 1'b0;
    match = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      match = (region == REGION_MAP[i*REGION_W +: REGION_W]);
      index = match ? SEL_W'(i) : index;
      hit   = hit | match;
    end
    mapped = hit | DEFAULT_OK;
  end

endmodule

// File: rtl/femto_bus_interconnect.sv
// Region-mapped interconnect between the FemtoRV32 mem_* bus and N slaves,
// with wait-state tracking, a busy watchdog and first-error capture.
module femto_bus_interconnect
  import femto_bus_pkg::*;
#(
  parameter int N_SLAVES = 8,
  parameter logic [N_SLAVES*REGION_W-1:0] REGION_MAP = DEFAULT_REGION_MAP,
  parameter int DEFAULT_SLAVE = 0,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT,
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [3:0]                 m_wmask,
  input  logic                       m_rstrb,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_rbusy,
  output logic                       m_wbusy,
  output logic [N_SLAVES-1:0]        s_cs,
  output logic                       s_rd,
  output logic                       s_wr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_rbusy,
  input  logic [N_SLAVES-1:0]        s_wbusy,
  input  logic                       err_clr,
  output logic                       err_valid,
  output logic                       err_ovf,
  output logic                       err_write,
  output logic                       err_timeout,
  output logic [DATA_W-1:0]          err_addr
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  bus_state_t         state_r, state_s;
  logic [SEL_W-1:0]   sel_r, sel_s;
  logic [DATA_W-1:0]  addr_r, addr_s;
  logic [7:0]         cnt_r, cnt_s;

  logic [SEL_W-1:0]   dec_index_s;
  logic               dec_hit_s, dec_mapped_s, access_ok_s;
  logic               wr_s, busy_s;
  logic               ev_s, ev_write_s, ev_timeout_s;
  logic [DATA_W-1:0]  ev_addr_s;
  logic [DATA_W-1:0]  slave_rdata [N_SLAVES];

  function automatic logic [N_SLAVES-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_SLAVES-1:0] v;
    v      = {N_SLAVES{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_rdata
    assign slave_rdata[g] = s_rdata[g*DATA_W +: DATA_W];
  end

  femto_bus_decode #(
    .N_SLAVES     (N_SLAVES),
    .REGION_MAP   (REGION_MAP),
    .DEFAULT_SLAVE(DEFAULT_SLAVE)
  ) u_decode (
    .region(m_addr[DATA_W-1:DATA_W-REGION_W]),
    .index (dec_index_s),
    .hit   (dec_hit_s),
    .mapped(dec_mapped_s)
  );

  assign access_ok_s = dec_mapped_s | dec_hit_s;
  assign wr_s        = |m_wmask;
  assign s_rd        = m_rstrb;
  assign s_wr        = wr_s;
  assign s_wdata     = m_wdata;

  // Next-state, bus outputs and error events; wait states use the latched selection.
  always_comb begin
    state_s      = state_r;
    sel_s        = sel_r;
    addr_s       = addr_r;
    cnt_s        = cnt_r;
    m_rdata      = slave_rdata[sel_r];
    m_rbusy      = 1'b0;
    m_wbusy      = 1'b0;
    s_cs         = {N_SLAVES{1'b0}};
    busy_s       = 1'b0;
    ev_s         = 1'b0;
    ev_write_s   = 1'b0;
    ev_timeout_s = 1'b0;
    ev_addr_s    = m_addr;
    case (state_r)
      ST_IDLE: begin
        m_wbusy = access_ok_s & s_wbusy[dec_index_s];
        if (m_rstrb | wr_s) begin
          s_cs = access_ok_s ? onehot(dec_index_s) : {N_SLAVES{1'b0}};
          if (!access_ok_s) begin
            ev_s       = 1'b1;
            ev_write_s = ~m_rstrb;
            state_s    = ST_ERR_RESP;
          end else if (m_rstrb | s_wbusy[dec_index_s]) begin
            sel_s   = dec_index_s;
            addr_s  = m_addr;
            cnt_s   = 8'd0;
            state_s = m_rstrb ? ST_RD_WAIT : ST_WR_WAIT;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          s_cs = {N_SLAVES{1'b0}};
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        s_cs   = onehot(sel_r);
        busy_s = (state_r == ST_RD_WAIT) ? s_rbusy[sel_r] : s_wbusy[sel_r];
        if (!busy_s) begin
          state_s = ST_IDLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s      = ST_IDLE;
          m_rdata      = ERR_DATA;
          ev_s         = 1'b1;
          ev_timeout_s = 1'b1;
          ev_write_s   = (state_r == ST_WR_WAIT);
          ev_addr_s    = addr_r;
        end else begin
          cnt_s   = cnt_r + 8'd1;
          m_rbusy = (state_r == ST_RD_WAIT);
          m_wbusy = (state_r == ST_WR_WAIT);
        end
      end
      ST_ERR_RESP: begin
        m_rdata = ERR_DATA;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Transaction state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      sel_r   <= {SEL_W{1'b0}};
      addr_r  <= 32'd0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
    end
  end

  // First-error capture; a clear in the same cycle as a new error lets it load.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid   <= 1'b0;
      err_ovf     <= 1'b0;
      err_write   <= 1'b0;
      err_timeout <= 1'b0;
      err_addr    <= 32'd0;
    end else if (ev_s && (!err_valid || err_clr)) begin
      err_valid   <= 1'b1;
      err_ovf     <= 1'b0;
      err_write   <= ev_write_s;
      err_timeout <= ev_timeout_s;
      err_addr    <= ev_addr_s;
    end else if (ev_s) begin
      err_ovf <= 1'b1;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_valid <= err_valid;
    end
  end

endmodule

// File: tb/tb_femto_bus_interconnect.sv
// Directed bench for femto_bus_interconnect: a transaction-level model checked
// every cycle, plus literal expectations taken from worked examples.
module tb_femto_bus_interconnect;

  localparam int          NS  = 8;
  localparam int          DEF = 8;
  localparam int          TO  = 255;
  localparam logic [31:0] ED  = 32'hDEADBEEF;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     m_addr = 32'd0, m_wdata = 32'd0;
  logic [3:0]      m_wmask = 4'd0;
  logic            m_rstrb = 1'b0;
  logic [31:0]     m_rdata;
  logic            m_rbusy, m_wbusy;
  logic [NS-1:0]   s_cs;
  logic            s_rd, s_wr;
  logic [31:0]     s_wdata;
  logic [NS*32-1:0] s_rdata = '0;
  logic [NS-1:0]   s_rbusy = '0, s_wbusy = '0;
  logic            err_clr = 1'b0;
  logic            err_valid, err_ovf, err_write, err_timeout;
  logic [31:0]     err_addr;
  logic [2:0]      tb_idx;
  logic            tb_hit, tb_mapped;

  logic [15:0] ref_map [NS] = '{16'h0000, 16'h0040, 16'h0041, 16'h0042,
                                16'h0043, 16'h0044, 16'h0001, 16'h0045};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  femto_bus_interconnect #(.N_SLAVES(NS), .DEFAULT_SLAVE(DEF), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rstrb(m_rstrb), .m_rdata(m_rdata), .m_rbusy(m_rbusy), .m_wbusy(m_wbusy),
    .s_cs(s_cs), .s_rd(s_rd), .s_wr(s_wr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .err_clr(err_clr), .err_valid(err_valid),
    .err_ovf(err_ovf), .err_write(err_write), .err_timeout(err_timeout), .err_addr(err_addr)
  );

  femto_bus_decode #(.N_SLAVES(NS), .DEFAULT_SLAVE(DEF)) u_ref_decode (
    .region(m_addr[31:16]), .index(tb_idx), .hit(tb_hit), .mapped(tb_mapped)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_index(input logic [31:0] a);
    int r = -1;
    for (int i = 0; i < NS; i++)
      if (r < 0 && a[31:16] == ref_map[i]) r = i;
    if (r < 0 && DEF < NS) r = DEF;
    return r;
  endfunction

  function automatic logic ref_hit(input logic [31:0] a);
    logic h = 1'b0;
    for (int i = 0; i < NS; i++) h = h | (a[31:16] == ref_map[i]);
    return h;
  endfunction

  function automatic logic [31:0] sd(input int i);
    return s_rdata[32*i +: 32];
  endfunction

  // Model: outstanding transaction kind 0 none, 1 read, 2 write, 3 error reply.
  int          md_mode = 0, md_tgt = 0, md_last = 0, md_waited = 0;
  logic [31:0] md_addr = 32'd0;
  logic        e_valid = 1'b0, e_ovf = 1'b0, e_write = 1'b0, e_to = 1'b0;
  logic [31:0] e_addr = 32'd0;

  initial forever begin
    int          idx, n_mode, n_tgt, n_last, n_waited;
    logic        wr, busy, ev, ev_w, ev_to, x_rbusy, x_wbusy;
    logic [31:0] x_rdata, n_addr, ev_a;
    logic [NS-1:0] x_cs;
    @(negedge clk);
    idx = ref_index(m_addr);
    wr  = (m_wmask != 4'd0);
    x_cs = '0; x_rbusy = 1'b0; x_wbusy = 1'b0; x_rdata = sd(md_last);
    n_mode = md_mode; n_tgt = md_tgt; n_last = md_last; n_waited = md_waited; n_addr = md_addr;
    ev = 1'b0; ev_w = 1'b0; ev_to = 1'b0; ev_a = m_addr;
    if (md_mode == 0) begin
      if (idx >= 0) x_wbusy = s_wbusy[idx];
      if (m_rstrb || wr) begin
        if (idx < 0) begin
          ev = 1'b1; ev_w = !m_rstrb; n_mode = 3;
        end else begin
          x_cs[idx] = 1'b1;
          if (m_rstrb || s_wbusy[idx]) begin
            n_mode = m_rstrb ? 1 : 2; n_tgt = idx; n_last = idx; n_addr = m_addr; n_waited = 0;
          end
        end
      end
    end else if (md_mode == 3) begin
      x_rdata = ED; n_mode = 0;
    end else begin
      busy = (md_mode == 1) ? s_rbusy[md_tgt] : s_wbusy[md_tgt];
      x_cs[md_tgt] = 1'b1;
      x_rdata = sd(md_tgt);
      if (!busy) n_mode = 0;
      else if (md_waited + 1 >= TO) begin
        n_mode = 0; x_rdata = ED; ev = 1'b1; ev_to = 1'b1; ev_w = (md_mode == 2); ev_a = md_addr;
      end else begin
        n_waited = md_waited + 1; x_rbusy = (md_mode == 1); x_wbusy = (md_mode == 2);
      end
    end
    check("rdata", m_rdata, x_rdata);
    check("rbusy", 32'(m_rbusy), 32'(x_rbusy));
    check("wbusy", 32'(m_wbusy), 32'(x_wbusy));
    check("cs", 32'(s_cs), 32'(x_cs));
    check("s_rd", 32'(s_rd), 32'(m_rstrb));
    check("s_wr", 32'(s_wr), 32'(wr));
    check("s_wdata", s_wdata, m_wdata);
    check("err_valid", 32'(err_valid), 32'(e_valid));
    check("err_ovf", 32'(err_ovf), 32'(e_ovf));
    check("err_write", 32'(err_write), 32'(e_write));
    check("err_timeout", 32'(err_timeout), 32'(e_to));
    check("err_addr", err_addr, e_addr);
    check("dec_mapped", 32'(tb_mapped), 32'(idx >= 0));
    check("dec_hit", 32'(tb_hit), 32'(ref_hit(m_addr)));
    if (idx >= 0) check("dec_index", 32'(tb_idx), idx);
    // Inputs are stable until the next rising edge, so commit its effect now.
    if (reset) begin
      md_mode = 0; md_tgt = 0; md_last = 0; md_waited = 0; md_addr = 32'd0;
      e_valid = 1'b0; e_ovf = 1'b0; e_write = 1'b0; e_to = 1'b0; e_addr = 32'd0;
    end else begin
      md_mode = n_mode; md_tgt = n_tgt; md_last = n_last; md_waited = n_waited; md_addr = n_addr;
      if (ev) begin
        if (!e_valid || err_clr) begin
          e_valid = 1'b1; e_ovf = 1'b0; e_write = ev_w; e_to = ev_to; e_addr = ev_a;
        end else e_ovf = 1'b1;
      end else if (err_clr) begin
        e_valid = 1'b0; e_ovf = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, drop;
    logic [31:0] extra_addr [2];
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = 32'hA500_0000 | 32'(i);
    s_rdata[31:0]   = 32'hF1A5_0000;
    s_rdata[127:96] = 32'h0000_0015;
    extra_addr[0] = 32'h0001_0008;
    extra_addr[1] = 32'h0045_000C;

    tick(); tick();
    @(negedge clk);
    check("rst_rdata", m_rdata, 32'hF1A5_0000);
    check("rst_rbusy", 32'(m_rbusy), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    tick(); reset = 1'b0;

    // Single-cycle read of the multiplier.
    m_addr = 32'h0042_0004; m_rstrb = 1'b1;
    @(negedge clk); check("mult_cs", 32'(s_cs), 32'h0000_0008);
    tick(); m_rstrb = 1'b0;
    @(negedge clk); check("mult_rdata", m_rdata, 32'h0000_0015);
    check("mult_rbusy", 32'(m_rbusy), 32'd0);
    tick();

    // Flash busy for 20 cycles with the address moving after the strobe.
    s_rbusy[0] = 1'b1; m_addr = 32'h0000_0010; m_rstrb = 1'b1;
    tick(); m_rstrb = 1'b0; m_addr = 32'h0040_0000; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_rbusy && s_cs == 8'h01) cnt++;
      tick();
    end
    s_rbusy[0] = 1'b0;
    @(negedge clk);
    check("flash_busy_cycles", cnt, 32'd20);
    check("flash_rbusy_end", 32'(m_rbusy), 32'd0);
    check("flash_rdata", m_rdata, 32'hF1A5_0000);
    check("flash_cs", 32'(s_cs), 32'h0000_0001);
    tick();

    // Zero-wait write, then a write held off by the slave for two cycles.
    m_addr = 32'h0043_0000; m_wdata = 32'h1234_5678; m_wmask = 4'hF;
    @(negedge clk); check("uart_cs", 32'(s_cs), 32'h0000_0010);
    tick(); m_wmask = 4'h0;
    s_wbusy[5] = 1'b1; m_addr = 32'h0044_0000; m_wmask = 4'h3;
    @(negedge clk); check("gpio_wbusy_fwd", 32'(m_wbusy), 32'd1);
    tick(); m_wmask = 4'h0;
    tick(); tick(); s_wbusy[5] = 1'b0;
    @(negedge clk); check("gpio_wbusy_end", 32'(m_wbusy), 32'd0);
    check("gpio_cs_held", 32'(s_cs), 32'h0000_0020);
    tick();

    // Slave 2 never releases busy: the watchdog aborts the read.
    m_addr = 32'h0041_0000; s_rbusy[2] = 1'b1; m_rstrb = 1'b1; drop = 0;
    for (int k = 1; k <= 400; k++) begin
      tick(); m_rstrb = 1'b0;
      @(negedge clk);
      if (!m_rbusy) begin drop = k; break; end
    end
    check("timeout_cycle", drop, 32'd255);
    check("timeout_rdata", m_rdata, 32'hDEAD_BEEF);
    tick(); s_rbusy[2] = 1'b0;
    @(negedge clk);
    check("to_err_valid", 32'(err_valid), 32'd1);
    check("to_err_timeout", 32'(err_timeout), 32'd1);
    check("to_err_write", 32'(err_write), 32'd0);
    check("to_err_addr", err_addr, 32'h0041_0000);

    // Clear, then unmapped write, then a second unmapped access.
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    @(negedge clk); check("clr_err_valid", 32'(err_valid), 32'd0);
    tick(); m_addr = 32'h1234_0000; m_wmask = 4'hF;
    @(negedge clk); check("unmapped_cs", 32'(s_cs), 32'd0);
    tick(); m_wmask = 4'h0;
    @(negedge clk);
    check("um_rdata", m_rdata, 32'hDEAD_BEEF);
    check("um_err_valid", 32'(err_valid), 32'd1);
    check("um_err_write", 32'(err_write), 32'd1);
    check("um_err_timeout", 32'(err_timeout), 32'd0);
    check("um_err_addr", err_addr, 32'h1234_0000);
    tick(); m_addr = 32'h0099_0000; m_rstrb = 1'b1;
    tick(); m_rstrb = 1'b0;
    @(negedge clk);
    check("ovf_set", 32'(err_ovf), 32'd1);
    check("ovf_addr_kept", err_addr, 32'h1234_0000);
    tick();

    // Clear coincident with a new unmapped read.
    m_addr = 32'h0050_0000; m_rstrb = 1'b1; err_clr = 1'b1;
    tick(); m_rstrb = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    check("clrnew_valid", 32'(err_valid), 32'd1);
    check("clrnew_addr", err_addr, 32'h0050_0000);
    check("clrnew_ovf", 32'(err_ovf), 32'd0);
    check("clrnew_write", 32'(err_write), 32'd0);
    tick();

    // Reads of the remaining regions, checked by the model.
    for (int j = 0; j < 2; j++) begin
      m_addr = extra_addr[j]; m_rstrb = 1'b1;
      tick(); m_rstrb = 1'b0;
      tick();
    end

    // Reset while a read is waiting.
    s_rbusy[0] = 1'b1; m_addr = 32'h0000_0020; m_rstrb = 1'b1;
    tick(); m_rstrb = 1'b0;
    @(negedge clk); check("pre_reset_rbusy", 32'(m_rbusy), 32'd1);
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("post_reset_rbusy", 32'(m_rbusy), 32'd0);
    check("post_reset_valid", 32'(err_valid), 32'd0);
    check("post_reset_ovf", 32'(err_ovf), 32'd0);
    check("post_reset_addr", err_addr, 32'd0);
    check("post_reset_rdata", m_rdata, 32'hF1A5_0000);
    tick(); s_rbusy[0] = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/femto_bus_interconnect.md
Name: femto_bus_interconnect

Overview:
- Parametrised successor to the fixed 7-way chip-select decoder and read mux of the femto SoC top.
- Sits between FemtoRV32 (mem_* bus) and N memory-mapped slaves: flash, BRAM, UART, mult and future peripherals.
- Adds a table-driven region map, a latched read select, busy forwarding, a bus-timeout watchdog, unmapped-access detection and a sticky error-capture register with an interrupt line.

Parameters:
- N_SLAVES, 8, number of slave channels (1..16).
- REGION_MAP, {16'h0000,16'h0040,16'h0041,16'h0042,16'h0043,16'h0044,16'h0001,16'h0045}, flattened N_SLAVES*16 table; entry i is matched against m_addr[31:16]; entry 0 is the least-significant 16 bits.
- DEFAULT_SLAVE, 0, channel used on no match; a value >= N_SLAVES makes unmatched accesses a bus error.
- TIMEOUT, 255, maximum busy cycles before the transaction is aborted (8-bit counter, 1..255).
- ERR_DATA, 32'hDEADBEEF, read data returned on an error or timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- m_addr  in  32  CPU address
- m_wdata  in  32  CPU write data
- m_wmask  in  4  CPU byte write mask; write = |m_wmask
- m_rstrb  in  1  CPU read strobe
- m_rdata  out  32  read data to the CPU
- m_rbusy  out  1  read busy to the CPU
- m_wbusy  out  1  write busy to the CPU
- s_cs  out  N_SLAVES  one-hot chip select
- s_rd  out  1  m_rstrb, forwarded
- s_wr  out  1  |m_wmask, forwarded
- s_wdata  out  32  m_wdata, forwarded
- s_rdata  in  N_SLAVES*32  slave read data, slave i at [32i+31:32i]
- s_rbusy  in  N_SLAVES  per-slave read busy
- s_wbusy  in  N_SLAVES  per-slave write busy
- err_clr  in  1  single-cycle pulse; clears the error register
- err_valid  out  1  sticky error flag; also the interrupt line
- err_ovf  out  1  set when a second error occurs while err_valid=1
- err_write  out  1  captured error was a write
- err_timeout  out  1  captured error was a timeout (0 = unmapped)
- err_addr  out  32  address of the captured error

Behaviour:
- Decode is combinational: hit[i] = (m_addr[31:16] == REGION_MAP[i]). Lowest index wins on duplicates.
- On no hit, DEFAULT_SLAVE is selected. If DEFAULT_SLAVE >= N_SLAVES, the access is unmapped and s_cs = 0.
- s_cs is the one-hot selection gated by (m_rstrb | s_wr | state != IDLE). The select is held through a wait state.
- FSM states: IDLE, RD_WAIT, WR_WAIT, ERR_RESP.
- IDLE, m_rstrb with a mapped address: latch sel_q <= index and addr_q <= m_addr, then go to RD_WAIT. Read strobe has priority over write in the same cycle.
- IDLE, write with a mapped address: if s_wbusy[index]=1, latch sel_q and addr_q and go to WR_WAIT; otherwise the write completes in the same cycle and the FSM stays in IDLE.
- IDLE, unmapped read or write: capture the error, go to ERR_RESP. In ERR_RESP the bus is not busy; m_rdata = ERR_DATA for one cycle, then IDLE.
- RD_WAIT: m_rdata = s_rdata[sel_q], m_rbusy = s_rbusy[sel_q].
  - Go to IDLE when s_rbusy[sel_q]=0. Slaves present registered data the cycle after the strobe, so read latency is 1 cycle when no slave is busy.
  - m_addr changes during RD_WAIT are ignored.
- WR_WAIT: m_wbusy = s_wbusy[sel_q]; go to IDLE when it is 0.
- Timeout: counter cleared on entry to RD_WAIT or WR_WAIT and incremented each busy cycle. On reaching TIMEOUT:
  - force m_rbusy/m_wbusy = 0 that cycle;
  - m_rdata = ERR_DATA;
  - capture the error with err_timeout=1;
  - return to IDLE.
- In IDLE, m_rdata = s_rdata[sel_q] (last selection), m_rbusy = 0, and m_wbusy = s_wbusy[current index].
- Error capture is first-error sticky: err_addr, err_write and err_timeout load only while err_valid=0. A later error sets err_ovf only.
- err_clr clears err_valid and err_ovf. If err_clr and a new error occur in the same cycle, the new error is captured and err_valid stays 1.
- Reset: state = IDLE, sel_q = 0, counter = 0, all err_* = 0, m_rbusy = 0, m_wbusy = 0. m_rdata follows s_rdata[0].
- Reset mid-transaction aborts it with no error recorded.

Decomposition:
- Package femto_bus_pkg:
  - FSM state encoding;
  - DATA_W = 32, REGION_W = 16;
  - default region constants RAM, DPRAM, UART, GPIO, MULT, DIV, BCD;
  - ERR_DATA default.
- One sub-module, femto_bus_decode: the combinational region match with priority encoding. Outputs are index, hit and mapped. It is reused by the testbench scoreboard.

Test Plan:
- Read at 0x00420004 (mult), s_rbusy=0, s_rdata[3]=0x00000015 → s_cs=0b00001000; m_rdata=0x15 one cycle later; m_rbusy=0.
- Read at 0x00000010, flash s_rbusy[0] high for 20 cycles; m_addr changed to 0x00400000 after the strobe → m_rbusy high for 20 cycles; data from slave 0 returned; s_cs stays at bit 0 throughout.
- TIMEOUT=255, slave 2 holds s_rbusy forever → m_rbusy drops at cycle 255; m_rdata=0xDEADBEEF; err_valid=1, err_timeout=1, err_addr=0x00410000.
- DEFAULT_SLAVE=8, write at 0x12340000 with wmask=0xF → s_cs=0; err_valid=1, err_write=1, err_timeout=0, err_addr=0x12340000. A second unmapped access sets err_ovf; err_addr is unchanged.
- err_clr pulse in the same cycle as a new unmapped read at 0x00500000 → err_valid stays 1, err_addr=0x00500000, err_ovf=0.
- Reset asserted in RD_WAIT → state returns to IDLE; all err_* are 0; m_rbusy=0 on the next cycle.
